// File: rtl/hc595_scan_driver_pkg.sv
// Shared types and constants for the 74HC595 scan driver and its shifter.
package hc595_scan_driver_pkg;

    localparam int         FRAME_W   = 16;
    localparam int         DP_BIT    = 7;
    localparam logic [7:0] SEG_BLANK = 8'hff;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_HOLD
    } scan_state_t;

    typedef enum logic [1:0] {
        SH_IDLE,
        SH_SHIFT,
        SH_LATCH
    } shift_state_t;

    // One-hot digit select byte, bit idx set.
    function automatic logic [7:0] digit_select(input logic [2:0] idx);
        digit_select = 8'h01 << idx;
    endfunction

endpackage

// File: rtl/hc595_scan_driver_if.sv
// Decoder link and 595 chain pins of the scan driver.
interface hc595_scan_driver_if;

    logic [3:0] digit_code;
    logic [7:0] seg_in;
    logic       ds;
    logic       shcp;
    logic       stcp;
    logic       oe_n;

    modport master (
        output digit_code,
        input  seg_in,
        output ds,
        output shcp,
        output stcp,
        output oe_n
    );

    modport slave (
        input  digit_code,
        output seg_in,
        input  ds,
        input  shcp,
        input  stcp,
        input  oe_n
    );

endinterface

// File: rtl/hc595_shifter.sv
// Generic N-bit MSB-first serialiser for a 595 chain: CLK_DIV-cycle shcp
// half-periods, followed by a CLK_DIV-cycle stcp latch pulse.
//
// state    | meaning
// ---------+--------------------------------------------------------
// SH_IDLE  | waiting for start_i; word captured on the start cycle
// SH_SHIFT | shifting bits; low half then high half of shcp per bit
// SH_LATCH | stcp high for CLK_DIV cycles, done_o on the last one
module hc595_shifter
    import hc595_scan_driver_pkg::*;
#(
    parameter int N       = FRAME_W,
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [N-1:0] data_i,
    output logic         ds_o,
    output logic         shcp_o,
    output logic         stcp_o,
    output logic         shift_end_o,
    output logic         done_o
);

    localparam int             PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int             BW         = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0]  PHASE_LAST = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0]  BIT_LAST   = BW'(N - 1);

    shift_state_t  state_q, state_d;
    logic [N-1:0]  sr_q, sr_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          high_q, high_d;
    logic          ds_q, ds_d;
    logic          shcp_q, shcp_d;
    logic          stcp_q, stcp_d;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SH_IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            phase_q <= '0;
            high_q  <= 1'b0;
            ds_q    <= 1'b0;
            shcp_q  <= 1'b0;
            stcp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            high_q  <= high_d;
            ds_q    <= ds_d;
            shcp_q  <= shcp_d;
            stcp_q  <= stcp_d;
        end
    end

    // Next state: phase and bit counters count down to terminal zero.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_d       = bit_q;
        phase_d     = phase_q;
        high_d      = high_q;
        ds_d        = ds_q;
        shcp_d      = shcp_q;
        stcp_d      = stcp_q;
        shift_end_o = 1'b0;
        done_o      = 1'b0;

        case (state_q)
            SH_IDLE: begin
                if (start_i) begin
                    sr_d    = data_i;
                    ds_d    = data_i[N-1];
                    shcp_d  = 1'b0;
                    high_d  = 1'b0;
                    phase_d = PHASE_LAST;
                    bit_d   = BIT_LAST;
                    state_d = SH_SHIFT;
                end
            end
            SH_SHIFT: begin
                if (phase_q == '0) begin
                    phase_d = PHASE_LAST;
                    if (!high_q) begin
                        shcp_d = 1'b1;
                        high_d = 1'b1;
                    end else begin
                        shcp_d = 1'b0;
                        high_d = 1'b0;
                        if (bit_q == '0) begin
                            shift_end_o = 1'b1;
                            stcp_d      = 1'b1;
                            state_d     = SH_LATCH;
                        end else begin
                            bit_d = bit_q - 1'b1;
                            sr_d  = {sr_q[N-2:0], 1'b0};
                            ds_d  = sr_q[N-2];
                        end
                    end
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            SH_LATCH: begin
                if (phase_q == '0) begin
                    stcp_d  = 1'b0;
                    done_o  = 1'b1;
                    state_d = SH_IDLE;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            default: state_d = SH_IDLE;
        endcase
    end

    assign ds_o   = ds_q;
    assign shcp_o = shcp_q;
    assign stcp_o = stcp_q;

endmodule

// File: rtl/hc595_scan_driver.sv
// Multiplexed scan driver for an 8-digit display on two cascaded 595s.
// Each digit slot: load segment/select word, shift 16 bits, latch, hold.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_LOAD  | one cycle; inputs sampled, word handed to the shifter
// ST_SHIFT | shifter clocking the 16-bit word out, MSB first
// ST_LATCH | stcp pulse; outputs enabled from its first cycle
// ST_HOLD  | digit displayed for HOLD_CYC cycles, then next digit
module hc595_scan_driver
    import hc595_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 4,
    parameter int HOLD_CYC   = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                bcd_data,
    input  logic [7:0]                 dp_en,
    input  logic [7:0]                 digit_en,
    hc595_scan_driver_if.master        bus,
    output logic [2:0]                 digit_idx,
    output logic                       frame_done
);

    localparam int            HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(NUM_DIGITS - 1);

    scan_state_t  state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic [HW-1:0] hold_q, hold_d;
    logic         oe_n_q, oe_n_d;
    logic         frame_done_q, frame_done_d;

    logic [7:0]         seg_merged;
    logic [FRAME_W-1:0] word;
    logic               start;
    logic               shift_end;
    logic               shift_done;

    // Scan state, digit index, hold timer and enable flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            idx_q        <= '0;
            hold_q       <= '0;
            oe_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            hold_q       <= hold_d;
            oe_n_q       <= oe_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Segment byte for the current digit: dp override, then blanking wins.
    always_comb begin
        seg_merged = bus.seg_in;
        if (dp_en[idx_q]) begin
            seg_merged[DP_BIT] = 1'b0;
        end
        if (!digit_en[idx_q]) begin
            seg_merged = SEG_BLANK;
        end
        word = {seg_merged, digit_select(idx_q)};
    end

    // Slot sequencing; digit index advances on the last hold cycle.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        hold_d       = hold_q;
        oe_n_d       = oe_n_q;
        frame_done_d = 1'b0;
        start        = 1'b0;

        case (state_q)
            ST_LOAD: begin
                start   = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (shift_end) begin
                    oe_n_d  = 1'b0;
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (shift_done) begin
                    hold_d  = HOLD_LAST;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_q == '0) begin
                    state_d = ST_LOAD;
                    if (idx_q >= IDX_LAST) begin
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    hc595_shifter #(
        .N       (FRAME_W),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .data_i      (word),
        .ds_o        (bus.ds),
        .shcp_o      (bus.shcp),
        .stcp_o      (bus.stcp),
        .shift_end_o (shift_end),
        .done_o      (shift_done)
    );

    assign bus.digit_code = bcd_data[{idx_q, 2'b00} +: 4];
    assign bus.oe_n       = oe_n_q;
    assign digit_idx      = idx_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_hc595_scan_driver.sv
// Bench for hc595_scan_driver: slot-timing reference model driven from
// cycle counts since reset, with a behavioural BCD-to-segment decoder.
module tb_hc595_scan_driver;

    localparam int N    = 8;
    localparam int CD   = 2;
    localparam int HOLD = 10;
    localparam int SLOT = 1 + 33 * CD + HOLD;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bcd_data;
    logic [7:0]  dp_en;
    logic [7:0]  digit_en;
    logic [2:0]  digit_idx;
    logic        frame_done;

    int n_chk = 0;
    int n_err = 0;

    hc595_scan_driver_if bus ();

    hc595_scan_driver #(
        .NUM_DIGITS (N),
        .CLK_DIV    (CD),
        .HOLD_CYC   (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_data   (bcd_data),
        .dp_en      (dp_en),
        .digit_en   (digit_en),
        .bus        (bus),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dec(input logic [3:0] c);
        case (c)
            4'h0: dec = 8'hc0;  4'h1: dec = 8'hf9;
            4'h2: dec = 8'ha4;  4'h3: dec = 8'hb0;
            4'h4: dec = 8'h99;  4'h5: dec = 8'h92;
            4'h6: dec = 8'h82;  4'h7: dec = 8'hf8;
            4'h8: dec = 8'h80;  4'h9: dec = 8'h90;
            4'ha: dec = 8'hbf;
            default: dec = 8'hff;
        endcase
    endfunction

    assign bus.seg_in = dec(bus.digit_code);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] model_word(input int idx);
        logic [31:0] b;
        logic [7:0]  s;
        b = bcd_data;
        if (!digit_en[idx]) begin
            s = 8'hff;
        end else begin
            s = dec(b[idx*4 +: 4]);
            if (dp_en[idx]) s = s & 8'h7f;
        end
        model_word = {s, 8'(1 << idx)};
    endfunction

    // Expected words for the first frame after power-up (directed inputs).
    logic [15:0] dir_tab [5] = '{16'hc001, 16'h7902, 16'ha404, 16'hff08, 16'hbf10};

    int          k       = 0;
    int          epoch   = 0;
    bit          active  = 1'b0;
    bit          rst_prev = 1'b0;
    bit          latched = 1'b0;
    logic [15:0] cur_word = '0;
    logic [15:0] cap      = '0;
    logic        prev_shcp = 1'b0;
    logic        prev_stcp = 1'b0;

    // Reference model: everything follows from cycle count since reset.
    always @(negedge clk) begin
        int          off, sl, idx;
        logic        e_shcp, e_stcp;
        logic [31:0] b;
        if (rst_prev) begin
            chk("rst_ds",    32'(bus.ds),    32'd0);
            chk("rst_shcp",  32'(bus.shcp),  32'd0);
            chk("rst_stcp",  32'(bus.stcp),  32'd0);
            chk("rst_oe_n",  32'(bus.oe_n),  32'd1);
            chk("rst_idx",   32'(digit_idx), 32'd0);
            chk("rst_fdone", 32'(frame_done), 32'd0);
            if (!rst) epoch++;
            k       = 0;
            active  = 1'b1;
            latched = 1'b0;
            cap     = '0;
        end else if (active) begin
            k++;
        end
        rst_prev = rst;

        if (active) begin
            sl  = k / SLOT;
            off = k % SLOT;
            idx = sl % N;
            b   = bcd_data;
            if (off == 0) cur_word = model_word(idx);
            if (off == 1 + 32 * CD) latched = 1'b1;
            e_shcp = (off >= 1 && off <= 32 * CD) && (((off - 1) % (2 * CD)) >= CD);
            e_stcp = (off >= 1 + 32 * CD) && (off <= 33 * CD);
            chk("shcp",       32'(bus.shcp),       32'(e_shcp));
            chk("stcp",       32'(bus.stcp),       32'(e_stcp));
            chk("oe_n",       32'(bus.oe_n),       32'(!latched));
            chk("digit_idx",  32'(digit_idx),      32'(idx));
            chk("frame_done", 32'(frame_done),     32'(off == 0 && sl > 0 && idx == 0));
            chk("digit_code", 32'(bus.digit_code), 32'(b[idx*4 +: 4]));
            if (off >= 1 && off <= 32 * CD)
                chk("ds", 32'(bus.ds), 32'(cur_word[15 - (off - 1) / (2 * CD)]));
            if (bus.shcp && !prev_shcp) cap = {cap[14:0], bus.ds};
            if (bus.stcp && !prev_stcp) begin
                chk("word", 32'(cap), 32'(cur_word));
                if (epoch == 1 && sl < 5) chk("dir_word", 32'(cap), 32'(dir_tab[sl]));
            end
        end
        prev_shcp = bus.shcp;
        prev_stcp = bus.stcp;
    end

    // One-cycle reset; returns #1 after the reset edge (slot cycle 0).
    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        bcd_data = 32'h765a3210;
        dp_en    = 8'h02;
        digit_en = 8'hf7;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // full frame plus wrap into the next one
        run(N * SLOT + 2 * SLOT);

        // input change in the middle of digit 2's shift
        bcd_data = 32'h01234567;
        digit_en = 8'hff;
        dp_en    = 8'h00;
        pulse_rst();
        run(2 * SLOT + 20);
        bcd_data = $urandom;
        run(3 * SLOT);

        // reset during bit 5 of digit 6
        pulse_rst();
        run(6 * SLOT + 21);
        pulse_rst();
        run(2 * SLOT);

        // randomized inputs, changes at arbitrary points, occasional resets
        for (int i = 0; i < 60; i++) begin
            run($urandom_range(1, 300));
            bcd_data = $urandom;
            dp_en    = 8'($urandom);
            digit_en = 8'($urandom | $urandom);
            if ($urandom_range(0, 7) == 0) pulse_rst();
        end
        run(N * SLOT + 5);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/hc595_scan_driver.md
Name: hc595_scan_driver

Overview:
- Time-multiplexed scan driver for the 8-digit display board built on two cascaded 74HC595s.
- Sits directly downstream of the BCD-to-segment decoder.
  - Presents the current digit's 4-bit code to the decoder.
  - Captures the decoder's active-low segment byte (bit7 = dp, bit0 = a).
  - Serialises segment byte plus digit select into the 595 chain, then latches.
- Cycles through all digits continuously for persistence-of-vision refresh.

Parameters:
- NUM_DIGITS, 8: number of scanned digits (1..8). Select byte is always 8 bits.
- CLK_DIV, 4: clk cycles per half-period of shcp (>=1).
- HOLD_CYC, 1000: clk cycles each digit stays latched before the next digit is loaded (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- bcd_data  in  32  digit i code = bcd_data[4i+3:4i]; code 4'ha = dash, >=4'hb = blank
- dp_en  in  8  bit i=1 lights dp of digit i
- digit_en  in  8  bit i=0 forces digit i blank (segment byte 8'hff)
- digit_code  out  4  code of current digit, to decoder input
- seg_in  in  8  decoder output for digit_code, active-low
- ds  out  1  595 serial data
- shcp  out  1  595 shift clock
- stcp  out  1  595 storage/latch clock
- oe_n  out  1  595 output enable, active-low
- digit_idx  out  3  index of digit currently being loaded/displayed
- frame_done  out  1  one-cycle pulse when the last digit's HOLD ends

Behaviour:
- Reset (sync, rst=1 at a clk edge) sets all outputs and state:
  - ds=0, shcp=0, stcp=0, oe_n=1, digit_idx=0, frame_done=0.
  - State LOAD, all counters 0.
  - Applies identically mid-operation; the partial frame is abandoned, with no latch pulse.
- digit_code is combinational from digit_idx: bcd_data[4*digit_idx +: 4].
- State LOAD (1 cycle): register word[15:0] = {S, sel}.
  - S = 8'hff if digit_en[idx]=0.
  - Otherwise S = seg_in with bit7 forced 0 when dp_en[idx]=1.
  - sel = one-hot, bit idx = 1, all other bits 0.
  - Then go to SHIFT.
- State SHIFT: 16 bits, MSB (word[15]) first.
  - Each bit: ds updated on entry to the low phase; shcp=0 for CLK_DIV cycles, then shcp=1 for CLK_DIV cycles.
  - shcp rises mid-bit, with ds stable at least CLK_DIV cycles either side.
  - Duration 32*CLK_DIV cycles; shcp ends low.
  - Then go to LATCH.
- State LATCH: stcp=1 for CLK_DIV cycles, then stcp=0.
  - oe_n goes 0 on the cycle stcp first rises and stays 0 until reset.
  - Then go to HOLD.
- State HOLD: wait HOLD_CYC cycles.
  - On the last cycle, digit_idx increments, wrapping NUM_DIGITS-1 -> 0.
  - At the wrap, frame_done=1 for exactly that cycle.
  - Then go to LOAD.
- Timing from the LOAD cycle:
  - stcp rises 1+32*CLK_DIV cycles later.
  - Digit slot length = 1 + 33*CLK_DIV + HOLD_CYC cycles (1133 at defaults).
- Input changes:
  - bcd_data, dp_en and digit_en may change at any time.
  - They are sampled only in LOAD; changes mid-shift affect only the next LOAD.
  - The latched digit never shows a mixed value.
- Counters: the bit counter is 4 bits wide, the phase counter covers CLK_DIV, the hold counter covers HOLD_CYC.
- Boundary cases:
  - NUM_DIGITS=1: digit_idx stays 0 and frame_done pulses every slot.
  - digit_idx never exceeds NUM_DIGITS-1.

Decomposition:
- Shared package holds:
  - State enum (LOAD, SHIFT, LATCH, HOLD).
  - SEG_BLANK = 8'hff.
  - Frame width constant 16.
  - Segment bit-position constant DP_BIT = 7.
- One natural sub-module: hc595_shifter.
  - Generic N-bit MSB-first serialiser with CLK_DIV phase timing and latch pulse.
  - Start/done handshake.
- The scan FSM, digit indexing and dp/blank merge stay in the top.
- The decoder is instantiated outside, at the parent level.

Test Plan:
- Single digit, seg 0xC0: CLK_DIV=2, HOLD_CYC=10, bcd_data=32'h76543210, all digits enabled, dp_en=0, decoder model attached -> digit 0 shifts word 16'hC001 MSB first; stcp rises exactly 65 cycles after LOAD; oe_n falls on that cycle.
- dp override: dp_en=8'h02 -> digit 1 word = 16'h7902 (0xF9 with bit7 cleared).
- Blanking and dash:
  - digit_en=8'hF7 -> digit 3 word 16'hFF08, regardless of code.
  - code 4'ha on digit 4 -> word 16'hBF10.
- Scan wrap: run a full frame -> digit_idx sequence 0..7; frame_done pulses once per 8 slots (slot = 1+66+10 = 77 cycles); next LOAD is idx 0.
- Mid-frame input change: change bcd_data during digit 2 shift -> shifted word unchanged; digit 3 reflects the new value.
- Reset mid-shift: assert rst for 1 cycle at bit 5 of digit 6 ->
  - Next edge: ds=shcp=stcp=0, oe_n=1, digit_idx=0, no stcp pulse.
  - Then digit 0 restarts; stcp rises 65 cycles after reset release.
